// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg : shared encodings and helpers for the data memory controller |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Wide enough to hold RAM_LATENCY-1 for the full 1..7 latency range.
  localparam int LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_WRITE     = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lsb[0];
      SIZE_WORD: return (lsb != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_lane_align : little-endian load extract/extend and store merge    |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_load_word,
  input  logic [1:0]  i_addr_lsb,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_load_word[7:0];
    case (i_addr_lsb)
      2'd0:    w_byte = i_load_word[7:0];
      2'd1:    w_byte = i_load_word[15:8];
      2'd2:    w_byte = i_load_word[23:16];
      default: w_byte = i_load_word[31:24];
    endcase
    w_half = i_addr_lsb[1] ? i_load_word[31:16] : i_load_word[15:0];
  end

  always_comb begin
    o_load_data = i_load_word;
    case (i_size)
      SIZE_BYTE: o_load_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SIZE_HALF: o_load_data = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default:   o_load_data = i_load_word;
    endcase
  end

  always_comb begin
    o_store_word = i_old_word;
    case (i_size)
      SIZE_BYTE: begin
        case (i_addr_lsb)
          2'd0:    o_store_word[7:0]   = i_wdata[7:0];
          2'd1:    o_store_word[15:8]  = i_wdata[7:0];
          2'd2:    o_store_word[23:16] = i_wdata[7:0];
          default: o_store_word[31:24] = i_wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (i_addr_lsb[1]) o_store_word[31:16] = i_wdata[15:0];
        else               o_store_word[15:0]  = i_wdata[15:0];
      end
      default: o_store_word = i_wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_ctrl : load/store controller with sub-word RMW over a RAM    |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int RAM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  output logic        ram_write_enable,
  input  logic [31:0] ram_data_out
);

  localparam logic [LAT_CNT_W-1:0] c_lat_load = LAT_CNT_W'(RAM_LATENCY - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LAT_CNT_W-1:0] r_lat_cnt;
  logic [LAT_CNT_W-1:0] w_lat_cnt_nxt;

  logic [1:0]  r_addr_lsb;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_write;
  logic [31:0] r_wdata;

  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;
  logic [31:0] r_ram_address;
  logic [31:0] r_ram_data_in;
  logic        r_ram_we;

  logic        w_resp_valid_nxt;
  logic [31:0] w_resp_rdata_nxt;
  logic        w_resp_error_nxt;
  logic [31:0] w_ram_address_nxt;
  logic [31:0] w_ram_data_in_nxt;
  logic        w_ram_we_nxt;

  logic        w_accept;
  logic        w_req_misaligned;
  logic [31:0] w_load_data;
  logic [31:0] w_store_word;

  assign req_ready        = (r_state == ST_IDLE) && !rst;
  assign w_accept         = req_valid && req_ready;
  assign w_req_misaligned = is_misaligned(req_size, req_addr[1:0]);

  assign resp_valid       = r_resp_valid;
  assign resp_rdata       = r_resp_rdata;
  assign resp_error       = r_resp_error;
  assign ram_address      = r_ram_address;
  assign ram_data_in      = r_ram_data_in;
  assign ram_write_enable = r_ram_we;

  mem_lane_align u_lane_align (
    .i_load_word  (ram_data_out),
    .i_addr_lsb   (r_addr_lsb),
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_old_word   (ram_data_out),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  // Request fields are frozen at acceptance so the requester may move on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_lsb <= 2'b00;
      r_size     <= SIZE_BYTE;
      r_unsigned <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= 32'h0;
    end else if (w_accept) begin
      r_addr_lsb <= req_addr[1:0];
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_write    <= req_write;
      r_wdata    <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_lat_cnt     <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= 32'h0;
      r_resp_error  <= 1'b0;
      r_ram_address <= 32'h0;
      r_ram_data_in <= 32'h0;
      r_ram_we      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lat_cnt     <= w_lat_cnt_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_resp_rdata  <= w_resp_rdata_nxt;
      r_resp_error  <= w_resp_error_nxt;
      r_ram_address <= w_ram_address_nxt;
      r_ram_data_in <= w_ram_data_in_nxt;
      r_ram_we      <= w_ram_we_nxt;
    end
  end

  // Outputs are computed one state ahead so each lands registered in its state.
  always_comb begin
    w_state_nxt       = r_state;
    w_lat_cnt_nxt     = r_lat_cnt;
    w_resp_valid_nxt  = 1'b0;
    w_resp_rdata_nxt  = 32'h0;
    w_resp_error_nxt  = 1'b0;
    w_ram_address_nxt = r_ram_address;
    w_ram_data_in_nxt = 32'h0;
    w_ram_we_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_ram_address_nxt = 32'h0;
        if (w_accept) begin
          if (w_req_misaligned) begin
            w_state_nxt      = ST_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_error_nxt = 1'b1;
          end else if (req_write && (req_size == SIZE_WORD)) begin
            w_state_nxt       = ST_WRITE;
            w_ram_address_nxt = {req_addr[31:2], 2'b00};
            w_ram_data_in_nxt = req_wdata;
            w_ram_we_nxt      = 1'b1;
          end else begin
            w_state_nxt       = ST_READ_WAIT;
            w_lat_cnt_nxt     = c_lat_load;
            w_ram_address_nxt = {req_addr[31:2], 2'b00};
          end
        end
      end

      ST_READ_WAIT: begin
        if (r_lat_cnt == '0) begin
          if (r_write) begin
            w_state_nxt       = ST_WRITE;
            w_ram_data_in_nxt = w_store_word;
            w_ram_we_nxt      = 1'b1;
          end else begin
            w_state_nxt       = ST_RESP;
            w_resp_valid_nxt  = 1'b1;
            w_resp_rdata_nxt  = w_load_data;
            w_ram_address_nxt = 32'h0;
          end
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - 1'b1;
        end
      end

      ST_WRITE: begin
        w_state_nxt       = ST_RESP;
        w_resp_valid_nxt  = 1'b1;
        w_ram_address_nxt = 32'h0;
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_ram_address_nxt = 32'h0;
      end
    endcase
  end

endmodule
`default_nettype wire
